// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with fill count, almost flags,
// optional first-word-fall-through read mode, flush and sticky errors.
module fifo_sync_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int AE_LEVEL   = 6,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 6,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] di,
  input  logic                  re,
  // read data; "do" is a reserved word
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty_flag,
  output logic                  full_flag,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  localparam logic [ADDR_WIDTH:0] C_FULL = CW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] C_AE   = CW'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0] C_AF   = CW'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] C_ONE  = CW'(1);

  localparam logic [ADDR_WIDTH-1:0] P_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   cnt_nxt;

  logic wr_acc;
  logic rd_acc;
  logic bypass;
  logic mem_we;
  logic mem_re;

  // In FWFT mode the head word lives in dout, so the RAM
  // holds count-1 words and is bypassed when it would be
  // the only word left.
  always_comb begin
    wr_acc = we && !full_flag && !clr;
    rd_acc = re && !empty_flag && !clr;
    bypass = 1'b0;
    if (FWFT != 0)
      bypass = wr_acc &&
               (empty_flag ||
                (rd_acc && count == C_ONE));
    mem_we = wr_acc && !bypass;
    mem_re = rd_acc &&
             ((FWFT == 0) || (count > C_ONE));
    cnt_nxt = count;
    unique case (1'b1)
      wr_acc && !rd_acc: cnt_nxt = count + C_ONE;
      rd_acc && !wr_acc: cnt_nxt = count - C_ONE;
      default:           cnt_nxt = count;
    endcase
    if (clr)
      cnt_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we)
      mem[wr_ptr] <= di;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty_flag   <= 1'b1;
      full_flag    <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      dout         <= '0;
    end else begin
      count        <= cnt_nxt;
      empty_flag   <= (cnt_nxt == '0);
      full_flag    <= (cnt_nxt == C_FULL);
      almost_empty <= (cnt_nxt <= C_AE);
      almost_full  <= (cnt_nxt >= C_AF);
      if (we && full_flag && !clr)
        overflow <= 1'b1;
      if (re && empty_flag && !clr)
        underflow <= 1'b1;
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (mem_we)
          wr_ptr <= wr_ptr + P_ONE;
        if (mem_re)
          rd_ptr <= rd_ptr + P_ONE;
      end
      if (bypass)
        dout <= di;
      else if (mem_re)
        dout <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: standard and FWFT instances share
// one stimulus stream and one queue model of the FIFO contents.
module tb_fifo_sync_param;

  localparam int DEPTH = 1024;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       we;
  logic       re;
  logic [7:0] di;

  logic [7:0]  s_do, f_do;
  logic        s_empty, s_full, s_ae, s_af, s_ov, s_un;
  logic        f_empty, f_full, f_ae, f_af, f_ov, f_un;
  logic [10:0] s_count, f_count;

  always #5 clk = ~clk;

  fifo_sync_param #(.FWFT(0)) u_std (
    .clk(clk), .rst(rst), .clr(clr),
    .we(we), .di(di), .re(re), .dout(s_do),
    .empty_flag(s_empty), .full_flag(s_full),
    .almost_empty(s_ae), .almost_full(s_af),
    .count(s_count),
    .overflow(s_ov), .underflow(s_un)
  );

  fifo_sync_param #(.FWFT(1)) u_fw (
    .clk(clk), .rst(rst), .clr(clr),
    .we(we), .di(di), .re(re), .dout(f_do),
    .empty_flag(f_empty), .full_flag(f_full),
    .almost_empty(f_ae), .almost_full(f_af),
    .count(f_count),
    .overflow(f_ov), .underflow(f_un)
  );

  int total = 0;
  int bad = 0;

  logic [7:0] q[$];
  logic [7:0] m_do;
  bit         m_ov;
  bit         m_un;
  bit         m_full;
  bit         m_emp;
  bit         chk_en = 1'b0;
  int         n_m;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
      m_do = 8'h00;
    end else if (clr) begin
      q.delete();
    end else begin
      m_full = (q.size() == DEPTH);
      m_emp  = (q.size() == 0);
      if (we && m_full) m_ov = 1'b1;
      if (re && m_emp)  m_un = 1'b1;
      if (re && !m_emp) m_do = q.pop_front();
      if (we && !m_full) q.push_back(di);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_m = q.size();
      chk("s_count", 32'(s_count), n_m);
      chk("f_count", 32'(f_count), n_m);
      chk("s_empty", 32'(s_empty), 32'(n_m == 0));
      chk("f_empty", 32'(f_empty), 32'(n_m == 0));
      chk("s_full", 32'(s_full), 32'(n_m == DEPTH));
      chk("f_full", 32'(f_full), 32'(n_m == DEPTH));
      chk("s_ae", 32'(s_ae), 32'(n_m <= 6));
      chk("f_ae", 32'(f_ae), 32'(n_m <= 6));
      chk("s_af", 32'(s_af), 32'(n_m >= 1018));
      chk("f_af", 32'(f_af), 32'(n_m >= 1018));
      chk("s_ov", 32'(s_ov), 32'(m_ov));
      chk("f_ov", 32'(f_ov), 32'(m_ov));
      chk("s_un", 32'(s_un), 32'(m_un));
      chk("f_un", 32'(f_un), 32'(m_un));
      chk("s_do", 32'(s_do), 32'(m_do));
      if (n_m != 0)
        chk("f_do", 32'(f_do), 32'(q[0]));
    end
  end

  task automatic drive(input logic w, input logic r,
                       input logic c, input logic [7:0] d);
    we  = w;
    re  = r;
    clr = c;
    di  = d;
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 8'h77);
    chk_en = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 8'h77);
    chk("rst_count", 32'(s_count), 0);
    chk("rst_empty", 32'(s_empty), 1);
    chk("rst_do", 32'(s_do), 0);
    chk("rst_fdo", 32'(f_do), 0);
    chk("rst_err", 32'({s_ov, s_un, f_ov, f_un}), 0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    chk("rst_nostore", 32'(f_count), 0);
    chk("rst_fempty", 32'(f_empty), 1);

    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'(i));
      if (i == 1016) chk("af_low", 32'(s_af), 0);
      if (i == 1017) begin
        chk("af_rise", 32'(s_af), 1);
        chk("af_cnt", 32'(s_count), 1018);
      end
    end
    chk("full_flag", 32'(s_full), 1);
    chk("full_cnt", 32'(s_count), 1024);
    drive(1'b1, 1'b0, 1'b0, 8'h55);
    chk("ovf_std", 32'(s_ov), 1);
    chk("ovf_fw", 32'(f_ov), 1);
    chk("ovf_cnt", 32'(s_count), 1024);

    for (int i = 0; i < DEPTH; i++) begin
      chk("fw_head", 32'(f_do), 32'(i & 255));
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      chk("drain_do", 32'(s_do), 32'(i & 255));
      if (i == 1016) chk("ae_low", 32'(s_ae), 0);
      if (i == 1017) begin
        chk("ae_rise", 32'(s_ae), 1);
        chk("ae_cnt", 32'(s_count), 6);
      end
    end
    chk("drain_empty", 32'(s_empty), 1);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    chk("unf_std", 32'(s_un), 1);
    chk("unf_fw", 32'(f_un), 1);
    chk("unf_hold", 32'(s_do), 32'h00ff);

    reset_dut();
    for (int i = 0; i < 500; i++)
      drive(1'b1, 1'b0, 1'b0, 8'(i));
    for (int k = 0; k < 2000; k++) begin
      drive(1'b1, 1'b1, 1'b0, 8'(500 + k));
      chk("sim_do", 32'(s_do), 32'(k & 255));
    end
    chk("sim_cnt", 32'(s_count), 500);
    for (int j = 0; j < 524; j++)
      drive(1'b1, 1'b0, 1'b0, 8'(2500 + j));
    chk("sim_full", 32'(s_full), 1);
    chk("sim_ov0", 32'(s_ov), 0);
    drive(1'b1, 1'b1, 1'b0, 8'hee);
    chk("wr_full_cnt", 32'(s_count), 1023);
    chk("wr_full_fcnt", 32'(f_count), 1023);
    chk("wr_full_ov", 32'(s_ov), 1);
    chk("wr_full_un", 32'(s_un), 0);
    chk("wr_full_do", 32'(s_do), 32'h00d0);

    reset_dut();
    drive(1'b1, 1'b0, 1'b0, 8'ha5);
    chk("fw_a5", 32'(f_do), 32'h00a5);
    chk("fw_a5_empty", 32'(f_empty), 0);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    chk("fw_pop_empty", 32'(f_empty), 1);
    chk("std_a5", 32'(s_do), 32'h00a5);
    for (int i = 0; i < 8; i++)
      drive(1'b1, 1'b0, 1'b0, 8'(16 + i));
    for (int k = 0; k < 8; k++) begin
      chk("fw_burst", 32'(f_do), 32'(16 + k));
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      chk("std_burst", 32'(s_do), 32'(16 + k));
    end
    chk("burst_empty", 32'(f_empty), 1);
    drive(1'b1, 1'b0, 1'b0, 8'h30);
    for (int k = 1; k < 5; k++) begin
      drive(1'b1, 1'b1, 1'b0, 8'(48 + k));
      chk("fw_pass", 32'(f_do), 32'(48 + k));
      chk("fw_pass_cnt", 32'(f_count), 1);
      chk("std_pass", 32'(s_do), 32'(47 + k));
    end
    drive(1'b0, 1'b1, 1'b0, 8'h00);

    reset_dut();
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 300; i++)
      drive(1'b1, 1'b0, 1'b0, 8'(i));
    chk("pre_clr_cnt", 32'(s_count), 300);
    drive(1'b1, 1'b1, 1'b1, 8'h99);
    chk("clr_cnt", 32'(s_count), 0);
    chk("clr_fcnt", 32'(f_count), 0);
    chk("clr_empty", 32'(s_empty), 1);
    chk("clr_fempty", 32'(f_empty), 1);
    chk("clr_full", 32'({s_full, s_af}), 0);
    chk("clr_un", 32'(s_un), 1);
    chk("clr_ov", 32'(s_ov), 0);
    chk("clr_hold", 32'(s_do), 0);
    drive(1'b1, 1'b0, 1'b0, 8'hc3);
    chk("post_fw", 32'(f_do), 32'h00c3);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    chk("post_std", 32'(s_do), 32'h00c3);
    chk("post_empty", 32'(s_empty), 1);
    drive(1'b0, 1'b0, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
